// File: rtl/record_play_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// audio_ctrl_pkg
// Shared definitions for the two-clip record/playback sequencer:
//   - state_t   : sequencer states (IDLE, REC, PLAY)
//   - CMD_*     : bit positions inside the 5-bit synchronizer command word
// ---------------------------------------------------------------------------
package audio_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REC  = 2'd1,
    PLAY = 2'd2
  } state_t;

  localparam int CMD_RST  = 4;
  localparam int CMD_REC  = 3;
  localparam int CMD_PLAY = 2;
  localparam int CMD_WSEL = 1;
  localparam int CMD_RSEL = 0;

endpackage

// File: rtl/record_play_ctrl_if.sv
// ---------------------------------------------------------------------------
// record_play_ctrl_if
// Clip memory bus driven by the sequencer.
//   mem_addr : {clip, offset}, CLIP_AW+1 bits, holds between strobes
//   mem_we   : one-cycle write strobe (recording)
//   mem_re   : one-cycle read strobe (playback)
// Strobe semantics: there is no back-pressure. A strobe is high for exactly
// one cycle and mem_addr is valid in that same cycle; the memory must accept
// every strobe. mem_we and mem_re are never high together.
// Modports: master = sequencer side, slave = memory side.
// ---------------------------------------------------------------------------
interface record_play_ctrl_if #(
  parameter int CLIP_AW = 14
);

  logic [CLIP_AW:0] mem_addr;
  logic             mem_we;
  logic             mem_re;

  modport master (
    output mem_addr,
    output mem_we,
    output mem_re
  );

  modport slave (
    input mem_addr,
    input mem_we,
    input mem_re
  );

endinterface

// File: rtl/record_play_ctrl_rise_detect.sv
// ---------------------------------------------------------------------------
// rise_detect
// Registered rising-edge detector, W independent bits.
//   clock : system clock
//   reset : synchronous active-high, clears the history to 0
//   din   : level inputs (already synchronous to clock)
//   rise  : high in the cycle din goes 0->1 relative to last cycle
// Because the history clears to 0, a level already high when reset drops
// is reported as a rising edge.
// ---------------------------------------------------------------------------
module rise_detect #(
  parameter int W = 1
) (
  input  logic         clock,
  input  logic         reset,
  input  logic [W-1:0] din,
  output logic [W-1:0] rise
);

  logic [W-1:0] hist_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      hist_q <= '0;
    end else begin
      hist_q <= din;
    end
  end

  assign rise = din & ~hist_q;

endmodule

// File: rtl/record_play_ctrl.sv
// ---------------------------------------------------------------------------
// record_play_ctrl
// Record/playback sequencer for the two-clip audio recorder. Detects
// record/play presses on the synchronizer command word and steps the clip
// memory address once per sample tick, tracking each clip's recorded length.
//
// Ports
//   clock       : system clock, posedge
//   reset       : synchronous active-high clear (cmd[4] does the same)
//   cmd[4:0]    : {reset, record, play, write-clip sel, read-clip sel}
//   sample_tick : one-cycle strobe at the audio sample rate
//   mem         : clip memory bus (master modport), strobes registered
//   recording   : high while in REC
//   playing     : high while in PLAY
//   done        : one-cycle pulse when REC or PLAY ends
//   state_dbg   : current sequencer state (IDLE/REC/PLAY encoding)
//
// Build option
//   LOOP_PLAY_EN : when defined, playback wraps to offset 0 after the last
//                  recorded sample and only stops on a record/play press.
// ---------------------------------------------------------------------------
module record_play_ctrl
  import audio_ctrl_pkg::*;
#(
  parameter int CLIP_AW = 14
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [4:0] cmd,
  input  logic       sample_tick,
  record_play_ctrl_if.master mem,
  output logic       recording,
  output logic       playing,
  output logic       done,
  output logic [1:0] state_dbg
);

  localparam logic [1:0] S_IDLE = 2'(IDLE);
  localparam logic [1:0] S_REC  = 2'(REC);
  localparam logic [1:0] S_PLAY = 2'(PLAY);

  localparam logic [CLIP_AW-1:0] OFF_ONE = 1;
  localparam logic [CLIP_AW:0]   LEN_ONE = 1;
  localparam logic [CLIP_AW:0]   DEPTH   = {1'b1, {CLIP_AW{1'b0}}};

  logic               clr;
  logic [1:0]         edges;
  logic               rec_edge;
  logic               play_edge;
  logic               stop_edge;

  logic [1:0]         state_q;
  logic               clip_q;
  logic [CLIP_AW-1:0] offset_q;
  logic [CLIP_AW:0]   len_q [2];
  logic [CLIP_AW:0]   addr_q;
  logic               we_q;
  logic               re_q;
  logic               done_q;
  logic               last_read;

  // The command-word reset bit is a full synchronous clear, same as reset.
  assign clr = reset | cmd[CMD_RST];

  rise_detect #(
    .W (2)
  ) u_rise (
    .clock (clock),
    .reset (clr),
    .din   (cmd[CMD_REC:CMD_PLAY]),
    .rise  (edges)
  );

  assign rec_edge  = edges[1];
  assign play_edge = edges[0];
  assign stop_edge = rec_edge | play_edge;

  // Offset of the last recorded sample; len_q is never 0 while in PLAY.
  assign last_read = ({1'b0, offset_q} == (len_q[clip_q] - LEN_ONE));

  always_ff @(posedge clock) begin
    if (clr) begin
      state_q  <= S_IDLE;
      clip_q   <= 1'b0;
      offset_q <= '0;
      len_q[0] <= '0;
      len_q[1] <= '0;
      addr_q   <= '0;
      we_q     <= 1'b0;
      re_q     <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      we_q   <= 1'b0;
      re_q   <= 1'b0;
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          // Record has priority over a simultaneous play press.
          if (rec_edge) begin
            clip_q   <= cmd[CMD_WSEL];
            offset_q <= '0;
            state_q  <= S_REC;
          end else if (play_edge) begin
            clip_q <= cmd[CMD_RSEL];
            if (len_q[cmd[CMD_RSEL]] != '0) begin
              offset_q <= '0;
              state_q  <= S_PLAY;
            end
          end
        end

        S_REC: begin
          // A stop press beats a coincident tick: no write is issued.
          if (stop_edge) begin
            len_q[clip_q] <= {1'b0, offset_q};
            done_q        <= 1'b1;
            state_q       <= S_IDLE;
          end else if (sample_tick) begin
            we_q     <= 1'b1;
            addr_q   <= {clip_q, offset_q};
            offset_q <= offset_q + OFF_ONE;
            if (offset_q == '1) begin
              len_q[clip_q] <= DEPTH;
              done_q        <= 1'b1;
              state_q       <= S_IDLE;
            end
          end
        end

        S_PLAY: begin
          if (stop_edge) begin
            done_q  <= 1'b1;
            state_q <= S_IDLE;
          end else if (sample_tick) begin
            re_q     <= 1'b1;
            addr_q   <= {clip_q, offset_q};
            offset_q <= offset_q + OFF_ONE;
            if (last_read) begin
`ifdef LOOP_PLAY_EN
              offset_q <= '0;
`else
              done_q  <= 1'b1;
              state_q <= S_IDLE;
`endif
            end
          end
        end

        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign mem.mem_addr = addr_q;
  assign mem.mem_we   = we_q;
  assign mem.mem_re   = re_q;
  assign recording    = (state_q == S_REC);
  assign playing      = (state_q == S_PLAY);
  assign done         = done_q;
  assign state_dbg    = state_q;

endmodule

// File: doc/record_play_ctrl.md
# record_play_ctrl

Record/playback sequencer for the two-clip audio recorder. Consumes the registered 5-bit command word from the button/switch synchronizer, detects record/play presses, and drives the clip memory address, write strobe and read strobe once per audio sample tick. Tracks the recorded length of each clip so playback stops at the end of recorded data.

## Interface
- `CLIP_AW`, default 14: per-clip offset width; clip depth = 2**CLIP_AW samples.
- `clock`  in  1  system clock; all logic on posedge.
- `reset`  in  1  synchronous, active-high; clears all state.
- `cmd`  in  5  synchronizer word: [4] reset, [3] record, [2] play, [1] write-clip select, [0] read-clip select.
- `sample_tick`  in  1  one-cycle strobe at the audio sample rate.
- `mem_addr`  out  CLIP_AW+1  {clip, offset}.
- `mem_we`  out  1  one-cycle write strobe (record).
- `mem_re`  out  1  one-cycle read strobe (playback).
- `recording`  out  1  high in REC.
- `playing`  out  1  high in PLAY.
- `done`  out  1  one-cycle pulse when REC or PLAY ends.

## Operation
- States: IDLE, REC, PLAY. Reset → IDLE. All outputs reset to 0. Both clip lengths reset to 0. Edge-detect history resets to 0.
- `cmd[4]` = 1 acts as a synchronous clear, identical to `reset`.
- Rising-edge detection on `cmd[3]` (rec_edge) and `cmd[2]` (play_edge).
- IDLE + rec_edge: latch clip = `cmd[1]`, offset = 0, go to REC. If rec_edge and play_edge occur in the same cycle, record wins.
- IDLE + play_edge:
  - latch clip = `cmd[0]`;
  - if len[clip] = 0, stay in IDLE with no `done`;
  - otherwise offset = 0, go to PLAY.
- REC, each `sample_tick`: write at {clip, offset}; offset increments.
- REC ends on either condition, then returns to IDLE with `done`:
  - the write at offset 2**CLIP_AW−1 (clip full); len[clip] = 2**CLIP_AW;
  - rec_edge or play_edge; len[clip] = number of samples written, possibly 0.
- PLAY, each `sample_tick`: read at {clip, offset}; offset increments.
- PLAY ends after the read at offset len[clip]−1, or on rec_edge/play_edge; returns to IDLE with `done`.
- A stop edge that ends REC/PLAY does not start a new operation. A new press is required.
- Length width is CLIP_AW+1 so a full clip is representable. Offset arithmetic is unsigned, CLIP_AW bits.

## Timing
- Strobes are registered. `mem_we`/`mem_re` and the matching `mem_addr` are valid the cycle after `sample_tick`.
- `mem_addr` holds its last value between strobes.
- Entering REC/PLAY: the first strobe occurs on the first `sample_tick` strictly after the transition cycle. A tick coincident with the start edge is ignored.
- Stop edge coincident with `sample_tick` in REC/PLAY: the stop wins and no strobe is issued.
- `done` is asserted the cycle after the terminating event; `recording`/`playing` drop in the same cycle.
- Reset mid-operation: immediate return to IDLE, no `done`, lengths cleared.

## Configuration
- `LOOP_PLAY_EN` defined: in PLAY, after the read at len[clip]−1, offset wraps to 0 and playback continues. Playback ends only on rec_edge/play_edge.
- `LOOP_PLAY_EN` undefined: one-shot playback as above.
- REC behaviour is identical in both builds.

## Structure
- Package `audio_ctrl_pkg`:
  - state enum {IDLE, REC, PLAY};
  - cmd bit index constants (CMD_RST=4, CMD_REC=3, CMD_PLAY=2, CMD_WSEL=1, CMD_RSEL=0).
- Sub-module `rise_detect`: parameterised-width registered rising-edge detector with synchronous reset. Instantiate it once for `cmd[3:2]`.

## Test plan
- Record: reset, CLIP_AW=4, cmd[3] rising with cmd[1]=1, 5 ticks, then cmd[3] rising again → `mem_we` ×5 at addr 16..20, `done` once, len[1]=5.
- Playback: after the above, cmd[2] rising with cmd[0]=1 → `mem_re` ×5 at addr 16..20, then `done`, IDLE. With `LOOP_PLAY_EN`: 6th read at addr 16.
- Full clip: record clip 0 for 16 ticks with no stop → 16 writes at addr 0..15, auto `done`, 17th tick produces no write.
- Empty clip: play_edge on clip 0 right after reset → stays IDLE, no `mem_re`, no `done`.
- Coincident events: rec_edge and play_edge in the same cycle → REC. Stop edge coincident with `sample_tick` → no strobe, `done`.
- Reset mid-PLAY: `reset` high for 1 cycle → all outputs 0 next cycle, no `done`, a later play_edge is ignored (len cleared).
